// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
// Holds the FSM state encoding, default width and iteration-counter sizing.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF);
  localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: cleared by reset, reloaded to zero on start, steps while enabled.
// Terminal-count flag marks the final iteration (WIDTH-1).
module multdiv_counter #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiplier / restoring divider working on operand magnitudes.
// WIDTH iteration steps plus one sign-correction cycle; any start restarts the unit.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               fin_q, fin_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic               start, tc;
  logic [WIDTH-1:0]   a_mag, b_mag, quo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     prod_hi;

  assign start = ctrl_MULT | ctrl_DIV;
  assign busy  = (state_q == MULT) || (state_q == DIV);

  multdiv_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (start),
    .en_i   (busy && !fin_q),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    fin_d   = fin_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;

    a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});
    // Divide: acc low half shifts dividend bits out and quotient bits in.
    div_diff = {rem_q, acc_q[WIDTH-1]} - {2'b00, mb_q};
    prod_s   = (sa_q ^ sb_q) ? -acc_q : acc_q;
    prod_hi  = prod_s[2*WIDTH-1:WIDTH-1];
    quo      = acc_q[WIDTH-1:0];

    if (start) begin
      state_d = ctrl_MULT ? MULT : DIV;
      ma_d    = a_mag;
      mb_d    = b_mag;
      sa_d    = data_operandA[WIDTH-1];
      sb_d    = data_operandB[WIDTH-1];
      acc_d   = {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
      rem_d   = '0;
      fin_d   = 1'b0;
    end else begin
      case (state_q)
        MULT: begin
          if (!fin_q) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            fin_d = tc;
          end else begin
            res_d   = prod_s[WIDTH-1:0];
            exc_d   = !((&prod_hi) || !(|prod_hi));
            rdy_d   = 1'b1;
            state_d = DONE;
          end
        end
        DIV: begin
          if (!fin_q) begin
            rem_d = div_diff[WIDTH+1] ? {rem_q[WIDTH-1:0], acc_q[WIDTH-1]} : div_diff[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
            fin_d = tc;
          end else begin
            if (mb_q == '0) begin
              res_d = '0;
              exc_d = 1'b1;
            end else if (sa_q ^ sb_q) begin
              res_d = -quo;
              exc_d = 1'b0;
            end else begin
              // A positive quotient with the top bit set only arises from INT_MIN / -1.
              res_d = quo;
              exc_d = quo[WIDTH-1];
            end
            rdy_d   = 1'b1;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      fin_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized operations
// compared against a plain-arithmetic signed multiply/divide reference.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks   = 0;
  int failures = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     qa, qb;
    if (is_mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      qa = $signed(a);
      qb = $signed(b);
      r  = qa / qb;
      e  = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 2000)) - 32'd1000;
      2: begin
        case ($urandom_range(0, 3))
          0:       v = 32'd0;
          1:       v = 32'd1;
          2:       v = 32'hFFFF_FFFF;
          default: v = 32'h8000_0000;
        endcase
      end
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  // Pulses a start, scrambles the operand inputs, then watches 40 edges.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int nrdy, output logic [31:0] res, output logic exc,
                       output logic [31:0] res_end, output logic busy_last, output logic busy_done);
    lat = -1; nrdy = 0; res = '0; exc = 1'b0; busy_last = 1'b0; busy_done = 1'b1;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (n == 32) busy_last = busy;
      if (n == 33) busy_done = busy;
      if (data_resultRDY) begin
        nrdy++;
        if (lat < 0) begin
          lat = n; res = data_result; exc = data_exception;
        end
      end
    end
    res_end = data_result;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if ({busy, data_resultRDY, data_exception, data_result} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b rdy=%b exc=%b res=%h want all zero",
               busy, data_resultRDY, data_exception, data_result);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    logic [31:0] ta[3] = '{32'd7, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] tb[3] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1};
    logic [31:0] tr[3] = '{32'hFFFF_FFD6, 32'h0000_0000, 32'h8000_0000};
    logic        te[3] = '{1'b0, 1'b1, 1'b0};
    int lat, nrdy; logic [31:0] res, res_end; logic exc, bl, bd;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 1'b0, ta[i], tb[i], lat, nrdy, res, exc, res_end, bl, bd);
      checks++;
      if (lat != 33 || nrdy != 1) begin
        failures++;
        $display("FAIL mult_timing[%0d] got lat=%0d rdys=%0d want lat=33 rdys=1", i, lat, nrdy);
      end
      checks++;
      if (res !== tr[i] || exc !== te[i]) begin
        failures++;
        $display("FAIL mult_value[%0d] got res=%h exc=%b want res=%h exc=%b", i, res, exc, tr[i], te[i]);
      end
      if (i == 0) begin
        checks++;
        if (bl !== 1'b1 || bd !== 1'b0) begin
          failures++;
          $display("FAIL busy_window got busy@32=%b busy@33=%b want 1 and 0", bl, bd);
        end
        checks++;
        if (res_end !== tr[i]) begin
          failures++;
          $display("FAIL result_hold got %h want %h", res_end, tr[i]);
        end
      end
    end
  endtask

  task automatic test_div;
    logic [31:0] ta[5] = '{32'hFFFF_FFF9, 32'd100, 32'd3, 32'd5, 32'h8000_0000};
    logic [31:0] tb[5] = '{32'd2, 32'hFFFF_FFF6, 32'd5, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] tr[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFF6, 32'd0, 32'd0, 32'h8000_0000};
    logic        te[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, nrdy; logic [31:0] res, res_end; logic exc, bl, bd;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, 1'b1, ta[i], tb[i], lat, nrdy, res, exc, res_end, bl, bd);
      checks++;
      if (lat != 33 || nrdy != 1) begin
        failures++;
        $display("FAIL div_timing[%0d] got lat=%0d rdys=%0d want lat=33 rdys=1", i, lat, nrdy);
      end
      checks++;
      if (res !== tr[i] || exc !== te[i]) begin
        failures++;
        $display("FAIL div_value[%0d] got res=%h exc=%b want res=%h exc=%b", i, res, exc, tr[i], te[i]);
      end
    end
  endtask

  task automatic test_random;
    int lat, nrdy; logic [31:0] a, b, res, res_end, er; logic exc, ee, bl, bd, m, d;
    for (int i = 0; i < 40; i++) begin
      a = pick_operand();
      b = pick_operand();
      m = 1'($urandom_range(0, 1));
      d = (i % 8 == 7) ? 1'b1 : ~m;
      model(m, a, b, er, ee);
      do_op(m, d, a, b, lat, nrdy, res, exc, res_end, bl, bd);
      checks++;
      if (lat != 33 || nrdy != 1 || res !== er || exc !== ee || res_end !== er) begin
        failures++;
        $display("FAIL random[%0d] %s a=%h b=%h got lat=%0d rdys=%0d res=%h exc=%b want lat=33 rdys=1 res=%h exc=%b",
                 i, m ? "mul" : "div", a, b, lat, nrdy, res, exc, er, ee);
      end
    end
  endtask

  task automatic test_restart;
    int lat, nrdy; logic [31:0] res, res_end; logic exc, bl, bd;
    nrdy = 0; lat = -1; res = '0;
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) nrdy++;
    end
    ctrl_DIV = 1'b1; data_operandA = 32'd20; data_operandB = 32'd4;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        nrdy++;
        if (lat < 0) begin lat = n; res = data_result; end
      end
    end
    checks++;
    if (lat != 33 || nrdy != 1 || res !== 32'd5) begin
      failures++;
      $display("FAIL restart got lat=%0d rdys=%0d res=%h want lat=33 rdys=1 res=00000005", lat, nrdy, res);
    end
    do_op(1'b1, 1'b1, 32'd6, 32'd3, lat, nrdy, res, exc, res_end, bl, bd);
    checks++;
    if (lat != 33 || nrdy != 1 || res !== 32'd18 || exc !== 1'b0) begin
      failures++;
      $display("FAIL priority got lat=%0d rdys=%0d res=%h exc=%b want lat=33 rdys=1 res=00000012 exc=0",
               lat, nrdy, res, exc);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nrdy; logic [31:0] res, res_end; logic exc, bl, bd;
    do_op(1'b1, 1'b0, 32'd5, 32'd7, lat, nrdy, res, exc, res_end, bl, bd);
    checks++;
    if (res_end !== 32'd35) begin
      failures++;
      $display("FAIL pre_reset_result got %h want 00000023", res_end);
    end
    ctrl_MULT = 1'b1; data_operandA = 32'h7FFF_FFFF; data_operandB = 32'h7FFF_FFFF;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state got busy=%b res=%h exc=%b rdy=%b want 0 0 0 0",
               busy, data_result, data_exception, data_resultRDY);
    end
    nrdy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) nrdy++;
    end
    checks++;
    if (nrdy != 0) begin
      failures++;
      $display("FAIL reset_mid_no_rdy got rdys=%0d want 0", nrdy);
    end
    do_op(1'b1, 1'b0, 32'd2, 32'd3, lat, nrdy, res, exc, res_end, bl, bd);
    checks++;
    if (lat != 33 || nrdy != 1 || res !== 32'd6 || exc !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_mult got lat=%0d rdys=%0d res=%h exc=%b want lat=33 rdys=1 res=00000006 exc=0",
               lat, nrdy, res, exc);
    end
  endtask

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    test_reset();
    test_mult();
    test_div();
    test_restart();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
